// File: rtl/tankwar_pkg.sv
// Shared TankWar definitions: direction codes and the direct[] field layout.
package tankwar_pkg;

   localparam int NUM_DIR      = 4;
   localparam int DIR_MOVE_BIT = 2;

   typedef enum logic [1:0] {
      LEFT  = 2'b00,
      RIGHT = 2'b01,
      UP    = 2'b10,
      DOWN  = 2'b11
   } dir_e;

   // direct[2] = move request, direct[1:0] = facing
   typedef struct packed {
      logic move;
      dir_e dir;
   } direct_t;

   // Lowest-index set bit wins (LEFT > RIGHT > UP > DOWN); callers pass a nonzero vector.
   function automatic dir_e lowest_dir(input logic [NUM_DIR-1:0] v);
      if (v[0])      return LEFT;
      else if (v[1]) return RIGHT;
      else if (v[2]) return UP;
      else           return DOWN;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-level debouncer with rise/fall pulses.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int DB_W            = 20
) (
   input  logic clk,
   input  logic rstn_i,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]      sync_q;
   logic            level_q, level_d;
   logic [DB_W-1:0] cnt_q, cnt_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;

   // Count consecutive disagreeing samples; accept the new level after DEBOUNCE_CYCLES of them.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
            rise_d  = sync_q[1];
            fall_d  = ~sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchroniser and debounce state; edge pulses coincide with the level change.
   always_ff @(posedge clk) begin
      if (!rstn_i) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], raw_i};
         level_q <= level_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/tank_input_ctrl.sv
// TankWar player input: debounce, last-pressed direction arbitration, rate-limited fire.
module tank_input_ctrl
   import tankwar_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int DB_W            = 20,
   parameter int COOLDOWN_FRAMES = 15,
   parameter int CD_W            = 4
) (
   input  logic         clk,
   input  logic         RSTN,
   input  logic [3:0]   BTN,
   input  logic         shoot_btn,
   input  logic         frame_tick,
   output logic [2:0]   direct,
   output logic         shoot
);

   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

   // Index 4 is the shoot button, 3:0 the direction buttons.
   logic [4:0] lvl, rise, fall;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_W            (DB_W)
   ) u_db [4:0] (
      .clk     (clk),
      .rstn_i  (RSTN),
      .raw_i   ({shoot_btn, BTN}),
      .level_o (lvl),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   // Only the press edge of the shoot button matters.
   logic unused_shoot;
   assign unused_shoot = ^{lvl[4], fall[4]};

   logic [3:0] held, btn_rise, btn_fall;
   logic       sh_rise;
   assign held     = lvl[3:0];
   assign btn_rise = rise[3:0];
   assign btn_fall = fall[3:0];
   assign sh_rise  = rise[4];

   dir_e            last_q, last_d;
   logic            valid_q, valid_d;
   direct_t         direct_q, direct_d;
   logic            pend_q, pend_d;
   logic [CD_W-1:0] cd_q, cd_d;
   logic            shoot_q, shoot_d;
   logic            fire;

   // Arbitration runs every cycle; outputs, cooldown and firing only advance on frame_tick.
   always_comb begin
      last_d   = last_q;
      valid_d  = valid_q;
      direct_d = direct_q;
      pend_d   = pend_q;
      cd_d     = cd_q;
      shoot_d  = 1'b0;
      fire     = frame_tick && (cd_q == '0) && pend_q;

      // A new press always wins over the release of the current direction.
      if (|btn_rise) begin
         last_d  = lowest_dir(btn_rise);
         valid_d = 1'b1;
      end else if (btn_fall[last_q]) begin
         if (|held) begin
            last_d  = lowest_dir(held);
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end

      if (frame_tick) begin
         direct_d.move = valid_q;
         if (valid_q) direct_d.dir = last_q;
         if (cd_q != '0) begin
            cd_d = cd_q - 1'b1;
         end else if (pend_q) begin
            shoot_d = 1'b1;
            pend_d  = 1'b0;
            cd_d    = CD_LOAD;
         end
      end

      // Presses during cooldown are dropped; a press on a tick waits for the next tick.
      if (sh_rise && (cd_q == '0) && !fire) pend_d = 1'b1;
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!RSTN) begin
         last_q   <= LEFT;
         valid_q  <= 1'b0;
         direct_q <= '0;
         pend_q   <= 1'b0;
         cd_q     <= '0;
         shoot_q  <= 1'b0;
      end else begin
         last_q   <= last_d;
         valid_q  <= valid_d;
         direct_q <= direct_d;
         pend_q   <= pend_d;
         cd_q     <= cd_d;
         shoot_q  <= shoot_d;
      end
   end

   assign direct = direct_q;
   assign shoot  = shoot_q;

endmodule

// File: tb/tb_tank_input_ctrl.sv
// Bench for tank_input_ctrl: frame-level vector table, hand corner cases, random frames
// checked every cycle against a sample-window reference model.
module tb_tank_input_ctrl;

   localparam int DC = 4;
   localparam int CD = 2;
   localparam int FRAME = 20;

   logic       clk = 1'b0;
   logic       RSTN = 1'b0;
   logic [3:0] BTN = 4'b0;
   logic       shoot_btn = 1'b0;
   logic       frame_tick = 1'b0;
   logic [2:0] direct;
   logic       shoot;

   int checks = 0;
   int errors = 0;

   tank_input_ctrl #(
      .DEBOUNCE_CYCLES (DC),
      .DB_W            (3),
      .COOLDOWN_FRAMES (CD),
      .CD_W            (2)
   ) dut (
      .clk        (clk),
      .RSTN       (RSTN),
      .BTN        (BTN),
      .shoot_btn  (shoot_btn),
      .frame_tick (frame_tick),
      .direct     (direct),
      .shoot      (shoot)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Raw samples per input, newest first; the debouncer sees index 2 (two sync stages).
   bit         m_hist[5][$];
   bit         m_s[5], m_rise[5], m_fall[5];
   bit         m_valid, m_pend, m_shoot;
   int         m_last, m_cd;
   logic [2:0] m_dir;

   function automatic int lowest(input bit [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 3;
   endfunction

   task automatic model_step();
      bit [3:0] r4, f4, h4;
      int nl, ncd;
      bit nv, npend, nsh, flip, raw;
      logic [2:0] ndir;
      if (!RSTN) begin
         for (int i = 0; i < 5; i++) begin
            m_hist[i].delete();
            repeat (DC + 2) m_hist[i].push_back(1'b0);
            m_s[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
         end
         m_valid = 0; m_pend = 0; m_shoot = 0; m_last = 0; m_cd = 0; m_dir = 3'b000;
         return;
      end
      for (int i = 0; i < 4; i++) begin
         r4[i] = m_rise[i]; f4[i] = m_fall[i]; h4[i] = m_s[i];
      end
      nl = m_last; nv = m_valid;
      if (r4 != 0) begin
         nl = lowest(r4); nv = 1;
      end else if (f4[m_last]) begin
         if (h4 != 0) begin nl = lowest(h4); nv = 1; end
         else nv = 0;
      end
      ndir = m_dir; npend = m_pend; ncd = m_cd; nsh = 0;
      if (frame_tick) begin
         ndir[2] = m_valid;
         if (m_valid) ndir[1:0] = 2'(m_last);
         if (m_cd > 0) ncd = m_cd - 1;
         else if (m_pend) begin nsh = 1; npend = 0; ncd = CD; end
      end
      if (m_rise[4] && m_cd == 0 && !nsh) npend = 1;
      // Level flips once the last DC synchronised samples all disagree with it.
      for (int i = 0; i < 5; i++) begin
         raw = (i < 4) ? BTN[i] : shoot_btn;
         m_hist[i].push_front(raw);
         void'(m_hist[i].pop_back());
         flip = 1;
         for (int k = 2; k < DC + 2; k++) if (m_hist[i][k] == m_s[i]) flip = 0;
         m_rise[i] = flip && !m_s[i];
         m_fall[i] = flip && m_s[i];
         if (flip) m_s[i] = !m_s[i];
      end
      m_last = nl; m_valid = nv; m_dir = ndir; m_pend = npend; m_cd = ncd; m_shoot = nsh;
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      checks++;
      if (direct !== m_dir || shoot !== m_shoot) begin
         errors++;
         $display("FAIL cycle t=%0t: direct=%b shoot=%b, model direct=%b shoot=%b",
                  $time, direct, shoot, m_dir, m_shoot);
      end
   endtask

   // One frame of FRAME cycles ending with the tick edge; shoot input changes at cycle sht_at.
   task automatic run_frame(input logic [3:0] btn, input logic sht, input int sht_at,
                            input bit chk, input logic [2:0] ed, input logic es, input int id);
      BTN = btn;
      for (int j = 0; j < FRAME; j++) begin
         if (j == sht_at) shoot_btn = sht;
         frame_tick = (j == FRAME - 1);
         cycle();
      end
      frame_tick = 1'b0;
      if (chk) begin
         checks++;
         if (direct !== ed || shoot !== es) begin
            errors++;
            $display("FAIL frame %0d: direct=%b shoot=%b, expected direct=%b shoot=%b",
                     id, direct, shoot, ed, es);
         end
      end
   endtask

   task automatic do_reset(input int n);
      RSTN = 1'b0;
      frame_tick = 1'b0;
      for (int j = 0; j < n; j++) cycle();
      RSTN = 1'b1;
      BTN = 4'b0;
      shoot_btn = 1'b0;
   endtask

   typedef struct {
      logic [3:0] btn;
      logic       sht;
      int         sht_at;
      logic [2:0] exp_dir;
      logic       exp_sh;
   } vec_t;

   vec_t tbl[$];

   initial begin
      // Direction arbitration rows, then shoot cooldown / hold / tick-coincident press.
      tbl.push_back('{4'b0001, 1'b0, 0, 3'b100, 1'b0});
      tbl.push_back('{4'b0000, 1'b0, 0, 3'b000, 1'b0});
      tbl.push_back('{4'b0100, 1'b0, 0, 3'b110, 1'b0});
      tbl.push_back('{4'b0110, 1'b0, 0, 3'b101, 1'b0});
      tbl.push_back('{4'b0100, 1'b0, 0, 3'b110, 1'b0});
      tbl.push_back('{4'b0000, 1'b0, 0, 3'b010, 1'b0});
      tbl.push_back('{4'b1001, 1'b0, 0, 3'b100, 1'b0});
      tbl.push_back('{4'b1000, 1'b0, 0, 3'b111, 1'b0});
      tbl.push_back('{4'b0000, 1'b0, 0, 3'b011, 1'b0});
      tbl.push_back('{4'b0000, 1'b1, 0, 3'b011, 1'b1});
      tbl.push_back('{4'b0000, 1'b0, 0, 3'b011, 1'b0});
      tbl.push_back('{4'b0000, 1'b1, 0, 3'b011, 1'b0});
      tbl.push_back('{4'b0000, 1'b0, 0, 3'b011, 1'b0});
      tbl.push_back('{4'b0000, 1'b1, 0, 3'b011, 1'b1});
      tbl.push_back('{4'b0000, 1'b1, 0, 3'b011, 1'b0});
      tbl.push_back('{4'b0000, 1'b1, 0, 3'b011, 1'b0});
      tbl.push_back('{4'b0000, 1'b1, 0, 3'b011, 1'b0});
      tbl.push_back('{4'b0000, 1'b0, 0, 3'b011, 1'b0});
      tbl.push_back('{4'b0000, 1'b1, 0, 3'b011, 1'b1});
      for (int k = 0; k < 9; k++) tbl.push_back('{4'b0000, 1'b1, 0, 3'b011, 1'b0});
      tbl.push_back('{4'b0000, 1'b0, 0, 3'b011, 1'b0});
      tbl.push_back('{4'b0000, 1'b1, 13, 3'b011, 1'b0});
      tbl.push_back('{4'b0000, 1'b1, 0, 3'b011, 1'b1});

      // Reset held with every button pressed: outputs stay cleared.
      RSTN = 1'b0; BTN = 4'hF; shoot_btn = 1'b1;
      for (int j = 0; j < 25; j++) begin
         frame_tick = (j == 10);
         cycle();
         checks++;
         if (direct !== 3'b000 || shoot !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: direct=%b shoot=%b, expected 000/0", direct, shoot);
         end
      end
      frame_tick = 1'b0; RSTN = 1'b1; BTN = 4'b0; shoot_btn = 1'b0;
      run_frame(4'b0000, 1'b0, 0, 1, 3'b000, 1'b0, 100);

      // 3-cycle glitch on LEFT is rejected.
      for (int j = 0; j < FRAME; j++) begin
         BTN = (j >= 2 && j < 5) ? 4'b0001 : 4'b0000;
         frame_tick = (j == FRAME - 1);
         cycle();
      end
      frame_tick = 1'b0;
      checks++;
      if (direct !== 3'b000) begin
         errors++;
         $display("FAIL glitch: direct=%b, expected 000", direct);
      end

      foreach (tbl[i])
         run_frame(tbl[i].btn, tbl[i].sht, tbl[i].sht_at, 1, tbl[i].exp_dir, tbl[i].exp_sh, i);

      // Reset mid-cooldown: a fresh press fires at the next tick.
      do_reset(3);
      run_frame(4'b0000, 1'b1, 0, 1, 3'b000, 1'b1, 200);
      run_frame(4'b0000, 1'b0, 0, 1, 3'b000, 1'b0, 201);
      run_frame(4'b0000, 1'b0, 0, 1, 3'b000, 1'b0, 202);
      // Pending press killed by reset leaves no stale pulse.
      shoot_btn = 1'b1;
      for (int j = 0; j < 10; j++) cycle();
      do_reset(3);
      run_frame(4'b0000, 1'b0, 0, 1, 3'b000, 1'b0, 203);
      run_frame(4'b0000, 1'b1, 0, 1, 3'b000, 1'b1, 204);

      // Random frames against the model.
      for (int f = 0; f < 60; f++)
         run_frame(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, FRAME - 1), 0, 3'b000, 1'b0, 300 + f);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
